// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator: internal width sizing
// and decimation-factor decoding.
package cic_pkg;

    localparam int MAX_DEC_FACTOR = 16;
    localparam int DEC_WIDTH      = $clog2(MAX_DEC_FACTOR) + 1;

    typedef logic [DEC_WIDTH-1:0] dec_factor_t;

    function automatic int cic_width(input int data_width, input int n_stages, input int q_delay);
        return data_width + n_stages * $clog2(MAX_DEC_FACTOR * q_delay);
    endfunction

    // Unsupported factors decode to a shift of 0, i.e. R = 1.
    function automatic logic [2:0] dec_log2(input dec_factor_t f);
        case (f)
            dec_factor_t'(1):  return 3'd0;
            dec_factor_t'(2):  return 3'd1;
            dec_factor_t'(4):  return 3'd2;
            dec_factor_t'(8):  return 3'd3;
            dec_factor_t'(16): return 3'd4;
            default:           return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cic_stage.sv
// One CIC stage: an integrator (running modular sum) or a comb (difference
// against a DELAY-deep history), selected by IS_COMB.
module cic_stage #(
    parameter int W       = 20,
    parameter bit IS_COMB = 1'b0,
    parameter int DELAY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] x_in,
    output logic signed [W-1:0] y_out
);

    if (!IS_COMB) begin : g_integ
        logic signed [W-1:0] acc_q;
        logic signed [W-1:0] acc_d;

        // y_out is the sum being stored, so cascaded integrators settle in one edge.
        assign y_out = acc_q + x_in;
        assign acc_d = en ? y_out : acc_q;

        always_ff @(posedge clk) begin
            if (rst) acc_q <= '0;
            else     acc_q <= acc_d;
        end
    end else begin : g_comb
        logic signed [W-1:0] dly_q [DELAY];
        logic signed [W-1:0] dly_d [DELAY];

        assign y_out = x_in - dly_q[DELAY-1];

        always_comb begin
            dly_d = dly_q;
            if (en) begin
                dly_d[0] = x_in;
                for (int i = 1; i < DELAY; i++) dly_d[i] = dly_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimation filter: N integrators at input rate, N combs at output rate,
// then gain removal by arithmetic shift and saturation to Q1.15.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_FRAC  = 15,
    parameter int Q          = 1,
    parameter int N          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DEC_WIDTH-1:0]  dec_factor,
    input  logic [DATA_WIDTH-1:0] cic_in,
    output logic [DATA_WIDTH-1:0] cic_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int W      = cic_width(DATA_WIDTH, N, Q);
    localparam int Q_LOG2 = $clog2(Q);
    localparam logic signed [W-1:0] SAT_MAX = W'((1 << DATA_FRAC) - 1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] integ_y [N];
    logic signed [W-1:0] comb_y  [N];
    logic signed [W-1:0] norm;
    logic [2:0]           r_log2;
    logic [DEC_WIDTH-1:0] term_cnt;
    logic [7:0]           norm_shift;

    logic [DEC_WIDTH-1:0]  count_q, count_d;
    logic signed [W-1:0]   dec_q, dec_d;
    logic                  strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0] cic_out_q, cic_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    assign x_ext = W'($signed(cic_in));

    for (genvar k = 0; k < N; k++) begin : g_integ
        logic signed [W-1:0] stage_x;
        if (k == 0) begin : g_first
            assign stage_x = x_ext;
        end else begin : g_next
            assign stage_x = integ_y[k-1];
        end
        cic_stage #(.W(W), .IS_COMB(1'b0), .DELAY(1)) u_integ (
            .clk(clk), .rst(rst), .en(valid_in), .x_in(stage_x), .y_out(integ_y[k])
        );
    end

    // Combs run off the decimated sample captured on the R-th input.
    for (genvar k = 0; k < N; k++) begin : g_comb
        logic signed [W-1:0] stage_x;
        if (k == 0) begin : g_first
            assign stage_x = dec_q;
        end else begin : g_next
            assign stage_x = comb_y[k-1];
        end
        cic_stage #(.W(W), .IS_COMB(1'b1), .DELAY(Q)) u_comb (
            .clk(clk), .rst(rst), .en(strobe_q), .x_in(stage_x), .y_out(comb_y[k])
        );
    end

    assign r_log2     = dec_log2(dec_factor);
    assign term_cnt   = (DEC_WIDTH'(1) << r_log2) - DEC_WIDTH'(1);
    assign norm_shift = 8'(N * (int'(r_log2) + Q_LOG2));
    assign norm       = comb_y[N-1] >>> norm_shift;

    always_comb begin
        count_d  = count_q;
        dec_d    = dec_q;
        strobe_d = 1'b0;
        if (valid_in) begin
            if (count_q >= term_cnt) begin
                count_d  = '0;
                dec_d    = integ_y[N-1];
                strobe_d = 1'b1;
            end else begin
                count_d = count_q + DEC_WIDTH'(1);
            end
        end
    end

    always_comb begin
        cic_out_d   = cic_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        valid_out_d = strobe_q;
        if (strobe_q) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            if (norm > SAT_MAX) begin
                cic_out_d = SAT_MAX[DATA_WIDTH-1:0];
                ovf_d     = 1'b1;
            end else if (norm < SAT_MIN) begin
                cic_out_d = SAT_MIN[DATA_WIDTH-1:0];
                unf_d     = 1'b1;
            end else begin
                cic_out_d = norm[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            dec_q       <= '0;
            strobe_q    <= 1'b0;
            cic_out_q   <= '0;
            valid_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            dec_q       <= dec_d;
            strobe_q    <= strobe_d;
            cic_out_q   <= cic_out_d;
            valid_out_q <= valid_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign cic_out   = cic_out_q;
    assign valid_out = valid_out_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator at default parameters (N=1, Q=1): each
// output is the floor of the mean of its group of R accepted samples.
module tb_cic_decimator;
    import cic_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    dec_factor_t dec_factor = dec_factor_t'(1);
    logic [15:0] cic_in = '0;
    logic [15:0] cic_out;
    logic        valid_out;
    logic        overflow;
    logic        underflow;

    cic_decimator dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .dec_factor(dec_factor),
        .cic_in(cic_in), .cic_out(cic_out), .valid_out(valid_out),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        bit          ovf;
        bit          unf;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    int   out_cnt  = 0;
    int   r_cur    = 1;
    int   grp_sum  = 0;
    int   grp_n    = 0;
    int   n_acc    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int r_of(input int df);
        if (df == 1 || df == 2 || df == 4 || df == 8 || df == 16) return df;
        return 1;
    endfunction

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    initial forever begin
        @(negedge clk);
        if (valid_out) begin
            out_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got valid_out with cic_out=%h, expected no output", cic_out);
            end else begin
                mon_e = sb.pop_front();
                check("cic_out", cic_out, mon_e.val);
                check("overflow", overflow, mon_e.ovf);
                check("underflow", underflow, mon_e.unf);
                check("output_edge", edge_n, mon_e.due);
            end
        end
    end

    // Reference model: group sum, floor division by R, clamp to Q1.15.
    task automatic drive(input bit v, input int x);
        exp_t e;
        int   q;
        @(negedge clk);
        valid_in = v;
        cic_in   = 16'(x);
        if (v) begin
            grp_sum += x;
            grp_n++;
            n_acc++;
            if (grp_n == r_cur) begin
                q = grp_sum / r_cur;
                if ((grp_sum % r_cur) != 0 && grp_sum < 0) q--;
                e.ovf = 1'b0;
                e.unf = 1'b0;
                if (q > 32767) begin
                    e.val = 16'h7FFF;
                    e.ovf = 1'b1;
                end else if (q < -32768) begin
                    e.val = 16'h8000;
                    e.unf = 1'b1;
                end else begin
                    e.val = 16'(q);
                end
                e.due = edge_n + 2;
                sb.push_back(e);
                grp_sum = 0;
                grp_n   = 0;
            end
        end
    endtask

    task automatic do_reset(input int df);
        @(negedge clk);
        rst        = 1'b1;
        valid_in   = 1'b0;
        dec_factor = dec_factor_t'(df);
        repeat (5) @(negedge clk);
        check("rst_cic_out", cic_out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        check("rst_pending", sb.size(), 0);
        rst     = 1'b0;
        grp_sum = 0;
        grp_n   = 0;
        n_acc   = 0;
        out_cnt = 0;
        r_cur   = r_of(df);
    endtask

    task automatic finish_phase();
        @(negedge clk);
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        check("output_count", out_cnt, n_acc / r_cur);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sweep [5] = '{1, 2, 4, 8, 16};
        int illegal [5] = '{3, 0, 20, 2, 8};
        int per;
        int ph;

        do_reset(1);
        for (int i = 0; i < 40; i++) drive(1'b1, i);
        finish_phase();

        do_reset(4);
        for (int i = 0; i < 32; i++) drive(1'b1, 16'h4000);
        finish_phase();

        do_reset(16);
        for (int i = 0; i < 64; i++) drive(1'b1, 32767);
        for (int i = 0; i < 64; i++) drive(1'b1, -32768);
        finish_phase();

        do_reset(8);
        for (int i = 0; i < 128; i++) drive((i % 2) == 0, 16'h1000);
        finish_phase();

        do_reset(8);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h2000);
        do_reset(8);
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h2000);
        finish_phase();

        foreach (sweep[s]) begin
            do_reset(sweep[s]);
            per = int'($urandom_range(40, 200));
            ph  = int'($urandom_range(0, 199));
            for (int i = 0; i < 4003; i++)
                drive(1'b1, $rtoi(0.9 * 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i + ph) / real'(per))));
            finish_phase();
        end

        foreach (illegal[s]) begin
            do_reset(illegal[s]);
            for (int i = 0; i < 400; i++)
                drive($urandom_range(0, 3) != 0, int'($signed(16'($urandom))));
            finish_phase();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
